conv_weight_scheduler: RTL and testbench

Layer-level sequencer for the dual-kernel weight BRAM feeding the 3x3 parallel conv core. It runs two phases per layer. In the load phase it pulses the BRAM write-address reset, then snoops the DMA AXI-Stream handshake to count the complete BRAM lines written. In the compute phase it steps the BRAM read address over every output-channel pair, waits out the BRAM read latency, starts the conv core, and waits for the core's done before moving on. It sits between the layer control registers and the weight BRAM controller / conv core pair.

---
 rtl/conv_weight_scheduler.sv | 173 +++++++++++++++++
 tb/tb_conv_weight_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_weight_scheduler.sv
// Layer sequencer for the dual-kernel weight BRAM: the load phase snoops the DMA stream,
// the compute phase walks every output-channel pair through the conv core.
module conv_weight_scheduler #(
    parameter int  BRAM_DEPTH     = 512,
    parameter int  BEATS_PER_LINE = 18,
    parameter int  RD_LATENCY     = 1,
    localparam int ADDR_W         = $clog2(BRAM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_skip_load,
    input  logic [ADDR_W:0]   i_num_pairs,
    input  logic              i_abort,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic              o_write_addr_rst,
    output logic              o_read_en,
    output logic [ADDR_W-1:0] o_read_addr,
    output logic              o_core_start,
    input  logic              i_core_done,
    output logic [ADDR_W-1:0] o_pair_idx,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);
    localparam int BEAT_W = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
    localparam int WAIT_W = 3;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);
    localparam logic [ADDR_W:0]   DEPTH_SAT = (ADDR_W+1)'(BRAM_DEPTH);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(RD_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, WRST, LOAD, FETCH, WAIT_RD, RUN, DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [ADDR_W:0]     line_q, line_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0]   pair_q, pair_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                err_q, err_d;
    logic                wrst_q, wrst_d;
    logic                rd_en_q, rd_en_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W:0]     n_sat;
    logic                beat_fire;
    logic                final_beat;
    logic                last_pair;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        line_d     = line_q;
        beat_d     = beat_q;
        wait_d     = wait_q;
        pair_d     = pair_q;
        err_d      = err_q;
        n_sat      = (i_num_pairs > DEPTH_SAT) ? DEPTH_SAT : i_num_pairs;
        beat_fire  = s_axis_tvalid && s_axis_tready;
        final_beat = (beat_q == LAST_BEAT) && (line_q == n_q - 1'b1);
        last_pair  = ({1'b0, pair_q} == n_q - 1'b1);

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    n_d    = n_sat;
                    pair_d = '0;
                    err_d  = 1'b0;
                    if (n_sat == '0)      state_d = DONE;
                    else if (i_skip_load) state_d = FETCH;
                    else                  state_d = WRST;
                end
            end
            WRST: begin
                beat_d  = '0;
                line_d  = '0;
                state_d = LOAD;
            end
            LOAD: begin
                if (beat_fire) begin
                    // tlast must mark exactly the last beat of the last line
                    if (s_axis_tlast != final_beat) err_d = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        line_d = line_q + 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                    if (final_beat) state_d = FETCH;
                end
            end
            FETCH: begin
                wait_d  = '0;
                state_d = WAIT_RD;
            end
            WAIT_RD: begin
                if (wait_q == LAST_WAIT) state_d = RUN;
                else                     wait_d  = wait_q + 1'b1;
            end
            RUN: begin
                if (i_core_done) begin
                    if (last_pair) begin
                        state_d = DONE;
                    end else begin
                        pair_d  = pair_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (i_abort && (state_q != IDLE)) begin
            state_d = IDLE;
            pair_d  = pair_q;
        end

        // Output registers are loaded from the next state so they line up with state_q
        wrst_d  = (state_d == WRST);
        rd_en_d = (state_d == FETCH);
        start_d = (state_d == RUN) && (state_q != RUN);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        addr_d  = (state_d == FETCH) ? pair_d : addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            line_q  <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            pair_q  <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            wrst_q  <= 1'b0;
            rd_en_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            line_q  <= line_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            pair_q  <= pair_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            wrst_q  <= wrst_d;
            rd_en_q <= rd_en_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_write_addr_rst = wrst_q;
    assign o_read_en        = rd_en_q;
    assign o_read_addr      = addr_q;
    assign o_core_start     = start_q;
    assign o_pair_idx       = pair_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_err            = err_q;

endmodule

// File: tb/tb_conv_weight_scheduler.sv
// Randomized bench for conv_weight_scheduler: a scripted layer model predicts every output each cycle.
module tb_conv_weight_scheduler;
    localparam int DEPTH = 512;
    localparam int BPL   = 18;
    localparam int RDL   = 1;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0, i_skip_load = 1'b0, i_abort = 1'b0, i_core_done = 1'b0;
    logic [AW:0]   i_num_pairs = '0;
    logic          s_axis_tvalid = 1'b0, s_axis_tready = 1'b0, s_axis_tlast = 1'b0;
    logic          o_write_addr_rst, o_read_en, o_core_start, o_busy, o_done, o_err;
    logic [AW-1:0] o_read_addr, o_pair_idx;

    always #5 clk = ~clk;

    conv_weight_scheduler #(.BRAM_DEPTH(DEPTH), .BEATS_PER_LINE(BPL), .RD_LATENCY(RDL)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_skip_load(i_skip_load),
        .i_num_pairs(i_num_pairs), .i_abort(i_abort), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .o_write_addr_rst(o_write_addr_rst), .o_read_en(o_read_en), .o_read_addr(o_read_addr),
        .o_core_start(o_core_start), .i_core_done(i_core_done), .o_pair_idx(o_pair_idx),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    // expected outputs for the current cycle, and the model's persistent state
    logic          e_wrst = 0, e_rd = 0, e_start = 0, e_busy = 0, e_done = 0, e_err = 0;
    logic [AW-1:0] e_addr = '0, e_pidx = '0;
    logic          m_err = 0;
    logic [AW-1:0] m_addr = '0, m_pidx = '0;
    bit            chk_en = 0;
    int            n_vec = 0, n_bad = 0;
    int            c_wrst = 0, c_rd = 0, c_start = 0, c_done = 0;
    int            cyc = 0, last_rd_cyc = 0, last_st_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            chk("write_addr_rst", o_write_addr_rst, e_wrst);
            chk("read_en", o_read_en, e_rd);
            chk("read_addr", o_read_addr, e_addr);
            chk("core_start", o_core_start, e_start);
            chk("pair_idx", o_pair_idx, e_pidx);
            chk("busy", o_busy, e_busy);
            chk("done", o_done, e_done);
            chk("err", o_err, e_err);
            c_wrst  += int'(o_write_addr_rst);
            c_rd    += int'(o_read_en);
            c_start += int'(o_core_start);
            c_done  += int'(o_done);
            if (o_read_en)    last_rd_cyc = cyc;
            if (o_core_start) last_st_cyc = cyc;
        end
    end

    // Advance one cycle; inputs irrelevant to the coming state get random noise
    task automatic tick(input bit busy);
        @(posedge clk);
        #1;
        i_start       = busy ? 1'($urandom) : 1'b0;
        i_abort       = 1'b0;
        i_core_done   = 1'($urandom);
        i_skip_load   = 1'($urandom);
        i_num_pairs   = (AW+1)'($urandom);
        s_axis_tvalid = 1'($urandom);
        s_axis_tready = 1'($urandom);
        s_axis_tlast  = 1'($urandom);
        e_wrst = 0; e_rd = 0; e_start = 0; e_done = 0;
        e_busy = busy;
        e_err  = m_err;
        e_addr = m_addr;
        e_pidx = m_pidx;
    endtask

    // One layer. dly<0 => random core latency 0..3; abort_at = pair to abort in; rst_at = beat to reset at
    task automatic run_layer(input int nreq, input bit skip, input int bad_beat, input bit no_final_last,
                             input int dly, input int abort_at, input int rst_at);
        int n, total, idx, d, j;
        bit v;
        n = (nreq > DEPTH) ? DEPTH : nreq;
        total = n * BPL;
        tick(0);
        i_start = 1'b1; i_num_pairs = (AW+1)'(nreq); i_skip_load = skip;
        m_err = 0; m_pidx = '0;
        tick(1);
        if (n == 0) begin
            e_done = 1;
            tick(0);
            return;
        end
        if (!skip) begin
            e_wrst = 1;
            tick(1);
            idx = 0;
            while (idx < total) begin
                if ($urandom_range(3) == 0) begin
                    v = 1'($urandom);
                    s_axis_tvalid = v;
                    s_axis_tready = v ? 1'b0 : 1'($urandom);
                    tick(1);
                end else begin
                    if (idx == rst_at) begin
                        s_axis_tvalid = 0; s_axis_tready = 0; s_axis_tlast = 0;
                        #1 rst_n = 1'b0;
                        #1;
                        m_err = 0; m_addr = '0; m_pidx = '0;
                        e_busy = 0; e_err = 0; e_addr = '0; e_pidx = '0;
                        chk("rst_async_busy", o_busy, 0);
                        chk("rst_async_pidx", o_pair_idx, 0);
                        tick(0);
                        tick(0);
                        rst_n = 1'b1;
                        tick(0);
                        return;
                    end
                    s_axis_tvalid = 1; s_axis_tready = 1;
                    s_axis_tlast  = (idx == bad_beat) || ((idx == total - 1) && !no_final_last);
                    if (s_axis_tlast != (idx == total - 1)) m_err = 1;
                    idx++;
                    tick(1);
                end
            end
        end
        for (int p = 0; p < n; p++) begin
            m_addr = AW'(p); m_pidx = AW'(p);
            e_addr = m_addr; e_pidx = m_pidx; e_rd = 1;
            repeat (RDL + 1) tick(1);
            e_start = 1;
            d = (dly < 0) ? $urandom_range(3) : dly;
            j = 0;
            while (1) begin
                if (j == d) begin
                    if (abort_at == p) begin
                        i_abort = 1; i_core_done = 0;
                        tick(0);
                        return;
                    end
                    i_core_done = 1;
                    tick(1);
                    break;
                end
                i_core_done = 0;
                tick(1);
                j++;
            end
        end
        e_done = 1;
        tick(0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int b_wrst, b_rd, b_st, b_dn;
        repeat (2) @(posedge clk);
        #1 chk_en = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // two-line load with gaps, then two pairs
        b_wrst = c_wrst; b_rd = c_rd; b_st = c_start; b_dn = c_done;
        run_layer(2, 0, -1, 0, -1, -1, -1);
        chk("s1_wrst_pulses", c_wrst - b_wrst, 1);
        chk("s1_reads", c_rd - b_rd, 2);
        chk("s1_starts", c_start - b_st, 2);
        chk("s1_dones", c_done - b_dn, 1);
        chk("s1_rd_to_start", last_st_cyc - last_rd_cyc, 2);
        chk("s1_err", o_err, 0);

        // resident weights, slow core
        b_wrst = c_wrst; b_rd = c_rd; b_st = c_start;
        run_layer(3, 1, -1, 0, 10, -1, -1);
        chk("s2_wrst_pulses", c_wrst - b_wrst, 0);
        chk("s2_starts", c_start - b_st, 3);
        chk("s2_last_addr", o_read_addr, 2);

        // framing errors: early tlast and missing final tlast
        run_layer(1, 0, 4, 1, -1, -1, -1);
        chk("s3_err_sticky", o_err, 1);
        run_layer(1, 1, -1, 0, 0, -1, -1);
        chk("s3_err_cleared", o_err, 0);

        // zero pairs, then saturated pair count
        b_rd = c_rd; b_dn = c_done;
        run_layer(0, 0, -1, 0, -1, -1, -1);
        chk("s4_no_reads", c_rd - b_rd, 0);
        chk("s4_dones", c_done - b_dn, 1);
        b_st = c_start;
        run_layer(1023, 1, -1, 0, 0, -1, -1);
        chk("s4_sat_starts", c_start - b_st, 512);
        chk("s4_sat_last_addr", o_read_addr, 511);

        // abort in pair 1 of 4, then a normal single pair
        b_dn = c_done;
        run_layer(4, 1, -1, 0, 2, 1, -1);
        chk("s5_abort_no_done", c_done - b_dn, 0);
        chk("s5_abort_pidx", o_pair_idx, 1);
        run_layer(1, 0, -1, 0, -1, -1, -1);
        chk("s5_after_abort_done", c_done - b_dn, 1);

        // reset mid-load, then the first scenario again
        run_layer(2, 0, -1, 0, -1, -1, 10);
        b_wrst = c_wrst; b_st = c_start; b_dn = c_done;
        run_layer(2, 0, -1, 0, -1, -1, -1);
        chk("s6_wrst_pulses", c_wrst - b_wrst, 1);
        chk("s6_starts", c_start - b_st, 2);
        chk("s6_dones", c_done - b_dn, 1);

        // random layers
        repeat (8) begin
            int n, bb;
            n  = $urandom_range(1, 4);
            bb = ($urandom_range(2) == 0) ? $urandom_range(0, n * BPL - 1) : -1;
            run_layer(n, 1'($urandom), bb, ($urandom_range(4) == 0), -1,
                      ($urandom_range(3) == 0) ? $urandom_range(0, n - 1) : -1, -1);
        end
        tick(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
